focus_metric_accum: RTL

Downstream consumer of the Sobel edge-magnitude stream produced by the VGA filter stage. It accumulates thresholded edge energy over a programmable region of interest each frame. At every frame boundary it reports a per-frame focus score, an edge-pixel count and a running peak score for the auto-focus logic. It runs in the VGA pixel clock domain, and its inputs are the filter's 8-bit magnitude plus the sync/blank signals delayed to align with it.

---
 rtl/focus_metric_accum.sv | 88 ++++++++
 1 files changed

// File: rtl/focus_metric_accum.sv
// focus_metric_accum: per-frame thresholded edge-energy score over a region of interest, with peak tracking.
// Ports: VGA_CLK/reset (async, active-high); pix_in/hs_in/vs_in/blank_n_in aligned magnitude stream;
// threshold, clear_peak controls; score/edge_count/short_frame/score_valid per-frame report;
// peak_score/peak_new running maximum.
module focus_metric_accum #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 480,
  parameter int ROI_X0 = 200,
  parameter int ROI_X1 = 599,
  parameter int ROI_Y0 = 120,
  parameter int ROI_Y1 = 359,
  parameter int SUM_W  = 32
) (
  input  logic             VGA_CLK,
  input  logic             reset,
  input  logic [7:0]       pix_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             blank_n_in,
  input  logic [7:0]       threshold,
  input  logic             clear_peak,
  output logic [SUM_W-1:0] score,
  output logic [19:0]      edge_count,
  output logic             score_valid,
  output logic             short_frame,
  output logic [SUM_W-1:0] peak_score,
  output logic             peak_new
);
  localparam logic [9:0] X0 = 10'(ROI_X0);
  localparam logic [9:0] X1 = 10'(ROI_X1);
  localparam logic [9:0] Y0 = 10'(ROI_Y0);
  localparam logic [9:0] Y1 = 10'(ROI_Y1);
  localparam logic [9:0] H  = 10'(HEIGHT);
  localparam int unused_width = WIDTH;
  typedef enum logic {SYNC, ACCUM} state_t;
  state_t           state;
  logic             vs_q, blank_q, vs_fall, blank_fall, hit, unused_hs;
  logic [9:0]       x, y;
  logic [SUM_W-1:0] sum;
  logic [19:0]      count;
  logic [SUM_W:0]   sum_add;
  assign unused_hs  = hs_in;
  assign vs_fall    = vs_q & ~vs_in;
  assign blank_fall = blank_q & ~blank_n_in;
  // vs_in gate keeps the frame-end sample out of the sum
  assign hit = state == ACCUM && vs_in && blank_n_in && x >= X0 && x <= X1 &&
               y >= Y0 && y <= Y1 && pix_in >= threshold;
  assign sum_add = {1'b0, sum} + (SUM_W+1)'(pix_in);
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      vs_q        <= 1'b0;
      blank_q     <= 1'b0;
      x           <= '0;
      y           <= '0;
      sum         <= '0;
      count       <= '0;
      score       <= '0;
      edge_count  <= '0;
      score_valid <= 1'b0;
      short_frame <= 1'b0;
      peak_score  <= '0;
      peak_new    <= 1'b0;
    end else begin
      vs_q        <= vs_in;
      blank_q     <= blank_n_in;
      x           <= !vs_in ? '0 : blank_n_in ? x + 10'd1 : blank_fall ? '0 : x;
      y           <= !vs_in ? '0 : (blank_fall && ~&y) ? y + 10'd1 : y;
      score_valid <= 1'b0;
      if (vs_fall) begin
        sum   <= '0;
        count <= '0;
        state <= ACCUM;
        if (state == ACCUM) begin
          score       <= sum;
          edge_count  <= count;
          short_frame <= y != H;
          score_valid <= 1'b1;
        end
      end else if (hit) begin
        sum   <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
        count <= count + {19'd0, ~&count};
      end
      peak_new   <= !clear_peak && score_valid && score > peak_score;
      peak_score <= clear_peak ? '0 : (score_valid && score > peak_score) ? score : peak_score;
    end
  end
endmodule
